serial_alu_unit: RTL and testbench

- Bit-serial counterpart of the team's parallel N-bit gate arrays: captures two N-bit operands and an opcode, then computes one result bit per clock, LSB first, through a single 1-bit logic/full-adder slice.
- Trades N cycles of latency for one bit-slice of logic.
- Sits behind the lab ALU operand registers.
- Returns a registered result, carry and zero flag with a start/busy/done handshake.

---
 rtl/serial_alu_unit.sv | 173 +++++++++++++++++
 tb/tb_serial_alu_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_unit.sv
// -----------------------------------------------------------------------------
// serial_alu_unit
//
// Bit-serial ALU. Operands and opcode are captured on a start request. One
// result bit is then produced per clock, LSB first, through a single 1-bit
// logic / full-adder slice. After N processing cycles, Y, C and Z are updated
// together and done pulses for one cycle.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy=0
//   op     in   opcode [2:0], captured with start
//   A, B   in   N-bit operands, captured with start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when Y/C/Z update
//   Y      out  registered N-bit result
//   C      out  carry (ADD) / no-borrow (SUB) flag, 0 for the other ops
//   Z      out  zero flag of the newly loaded Y
//
// Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 NOTA,
//          110/111 reserved (result 0, C=0, still N cycles with done).
// -----------------------------------------------------------------------------
module serial_alu_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y,
  output logic         C,
  output logic         Z
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Partial result holds the N-1 bits finished before the final cycle; the
  // last bit comes straight from the slice on the completion edge.
  localparam int RW = (N > 1) ? N - 1 : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;
  logic [RW-1:0]  res_q;

  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   y_q;
  logic           c_q;
  logic           z_q;

  // ---------------------------------------------------------------------------
  // 1-bit slice
  // ---------------------------------------------------------------------------
  logic           b_eff;
  logic           sum_bit;
  logic           carry_d;
  logic           res_bit;
  logic           arith_op;
  logic           last_bit;
  logic [RW-1:0]  res_d;
  logic [N-1:0]   full_res;

  always_comb begin
    // SUB is A + ~B + 1: invert B here, the +1 is the preset carry_in.
    b_eff    = b_q[0] ^ (op_q == OP_SUB);
    sum_bit  = a_q[0] ^ b_eff ^ carry_q;
    carry_d  = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);
    arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);
    last_bit = (cnt_q == CW'(N - 1));
    res_bit  = 1'b0;
    case (op_q)
      OP_AND:  res_bit = a_q[0] & b_q[0];
      OP_OR:   res_bit = a_q[0] | b_q[0];
      OP_XOR:  res_bit = a_q[0] ^ b_q[0];
      OP_ADD:  res_bit = sum_bit;
      OP_SUB:  res_bit = sum_bit;
      OP_NOTA: res_bit = ~a_q[0];
      default: res_bit = 1'b0;
    endcase
  end

  generate
    if (N == 1) begin : g_single
      assign res_d    = 1'b0;
      assign full_res = res_bit;
    end else begin : g_multi
      always_comb begin
        res_d       = res_q >> 1;
        res_d[RW-1] = res_bit;
      end
      assign full_res = {res_bit, res_q};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= (op == OP_SUB);
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            y_q     <= full_res;
            c_q     <= arith_op ? carry_d : 1'b0;
            z_q     <= (full_res == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y    = y_q;
  assign C    = c_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_serial_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_unit
//
// Directed bench for serial_alu_unit (N=4). Expected results come from a
// word-level reference model, are queued when an operation is launched, and
// are popped and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_serial_alu_unit;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Y;
  logic         C;
  logic         Z;

  serial_alu_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .C     (C),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] y;
    logic         c;
    logic         z;
    string        tag;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_cyc;
  logic [N-1:0] y_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input string tag);
    exp_t e;
    logic [N:0] wide;
    e.c = 1'b0;
    e.y = '0;
    case (o)
      3'b000: e.y = a & b;
      3'b001: e.y = a | b;
      3'b010: e.y = a ^ b;
      3'b011: begin wide = {1'b0, a} + {1'b0, b}; e.y = wide[N-1:0]; e.c = wide[N]; end
      3'b100: begin e.y = a - b; e.c = (a >= b); end
      3'b101: e.y = ~a;
      default: e.y = '0;
    endcase
    e.z   = (e.y == '0);
    e.tag = tag;
    return e;
  endfunction

  // Present a request in the current cycle; it is sampled at the next edge.
  task automatic launch(input logic [2:0] o, input logic [N-1:0] a,
                        input logic [N-1:0] b, input string tag);
    exp_q.push_back(model(o, a, b, tag));
    y_hold = Y;
    op     = o;
    A      = a;
    B      = b;
    start  = 1'b1;
    step();
    start     = 1'b0;
    start_cyc = cyc;
    $display("[TB] start %s op=%b A=%b B=%b at cycle %0d", tag, o, a, b, cyc);
  endtask

  // Wait for done (bounded), checking busy and Y stability, then score.
  task automatic wait_done();
    exp_t e;
    while (!done && (cyc - start_cyc) < 20) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("y_hold",   {{(32-N){1'b0}}, Y}, {{(32-N){1'b0}}, y_hold});
      step();
    end
    chk("latency", cyc - start_cyc, N);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0 + exp_q.size());
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_Y"}, {{(32-N){1'b0}}, Y}, {{(32-N){1'b0}}, e.y});
      chk({e.tag, "_C"}, {31'b0, C}, {31'b0, e.c});
      chk({e.tag, "_Z"}, {31'b0, Z}, {31'b0, e.z});
      chk({e.tag, "_busy0"}, {31'b0, busy}, 32'd0);
      $display("[TB] done %s Y=%b C=%b Z=%b (exp Y=%b C=%b Z=%b) cycle %0d",
               e.tag, Y, C, Z, e.y, e.c, e.z, cyc);
    end
  endtask

  task automatic done_drops(input string tag);
    step();
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    #12;
    chk("rst_Y",    {{(32-N){1'b0}}, Y}, 32'd0);
    chk("rst_C",    {31'b0, C},    32'd0);
    chk("rst_Z",    {31'b0, Z},    32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);

    // AND with single-cycle done pulse
    launch(3'b000, 4'b1100, 4'b1010, "and");
    wait_done();
    done_drops("and");

    // ADD / SUB boundaries
    launch(3'b011, 4'b1111, 4'b0001, "add_wrap");
    wait_done();
    launch(3'b011, 4'b0110, 4'b0011, "add");
    wait_done();
    launch(3'b100, 4'b0101, 4'b0011, "sub_pos");
    wait_done();
    launch(3'b100, 4'b0011, 4'b0101, "sub_neg");
    wait_done();
    launch(3'b100, 4'b0111, 4'b0111, "sub_zero");
    wait_done();
    launch(3'b001, 4'b0100, 4'b0001, "or");
    wait_done();
    launch(3'b101, 4'b0110, 4'b0000, "nota");
    wait_done();
    launch(3'b110, 4'b1111, 4'b1111, "rsv6");
    wait_done();
    launch(3'b111, 4'b1010, 4'b0101, "rsv7");
    wait_done();
    done_drops("rsv7");

    // Load a nonzero Y so the hold check during the next run is meaningful.
    launch(3'b010, 4'b0110, 4'b0000, "xor_pre");
    wait_done();
    // Start while busy must be ignored; operand changes must not matter.
    launch(3'b000, 4'b1100, 4'b1010, "and_busy");
    op    = 3'b011;
    A     = 4'b1111;
    B     = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    A     = 4'b0000;
    B     = 4'b1111;
    wait_done();
    // Back-to-back: request presented in the done cycle.
    launch(3'b011, 4'b0110, 4'b0011, "b2b_add");
    chk("b2b_done_low", {31'b0, done}, 32'd0);
    wait_done();
    done_drops("b2b_add");

    // Asynchronous reset mid-operation
    launch(3'b010, 4'b1111, 4'b0101, "xor_abort");
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_Y",    {{(32-N){1'b0}}, Y}, 32'd0);
    chk("abort_C",    {31'b0, C},    32'd0);
    chk("abort_Z",    {31'b0, Z},    32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    $display("[TB] reset asserted mid-run at cycle %0d", cyc);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", {31'b0, done}, 32'd0);
    end
    launch(3'b010, 4'b1111, 4'b0101, "xor_after");
    wait_done();

    // A few random back-to-back operations
    for (int i = 0; i < 10; i++) begin
      launch(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), "rand");
      wait_done();
    end
    done_drops("rand");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
